// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e              : sequencing FSM states (RUN, MDU_WAIT)
//   FWD_RF/FWD_WB/FWD_MEM: ALU operand source selects
//   DEFAULT_MDU_TIMEOUT  : default MDU watchdog length in cycles
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned DEFAULT_MDU_TIMEOUT = 64;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding for the execute-stage ALU.
//   rs1_addr_i, rs2_addr_i : execute-stage source registers
//   dst_m_i, wr_m_i        : memory-stage destination / write enable
//   dst_w_i, wr_w_i        : writeback-stage destination / write enable
//   fwd_a_o, fwd_b_o       : operand selects (memory stage wins over writeback, x0 never forwarded)
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic [4:0] dst_m_i,
    input  logic       wr_m_i,
    input  logic [4:0] dst_w_i,
    input  logic       wr_w_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] dst_m, input logic wr_m,
                                           input logic [4:0] dst_w, input logic wr_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (dst_m != 5'd0) && (dst_m == rs)) begin
            sel = FWD_MEM;
        end else if (wr_w && (dst_w != 5'd0) && (dst_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_o = fwd_sel(rs1_addr_i, dst_m_i, wr_m_i, dst_w_i, wr_w_i);
        fwd_b_o = fwd_sel(rs2_addr_i, dst_m_i, wr_m_i, dst_w_i, wr_w_i);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller for the five-stage core.
//   Forwarding   : fwd_aE / fwd_bE select the execute ALU operand sources.
//   Hazards      : load-use stalls and branch flushes on stallF/stallD/flushD/flushE.
//   MDU sequencer: mdu_start / mdu_done handshake with a MDU_TIMEOUT-cycle watchdog;
//                  mdu_error is a sticky abort flag cleared only by rst_n.
//   Counters     : stall_cycles / flush_count, built only when HAZARD_PERF_EN is
//                  defined; otherwise tied to zero.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = DEFAULT_MDU_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addrD,
    input  logic [4:0]  rs2_addrD,
    input  logic        uses_rs1D,
    input  logic        uses_rs2D,
    input  logic        mdu_reqD,
    input  logic [4:0]  rs1_addrE,
    input  logic [4:0]  rs2_addrE,
    input  logic [4:0]  dstreg_addrE,
    input  logic        write_regE,
    input  logic [2:0]  info_loadE,
    input  logic        branch_takenE,
    input  logic [4:0]  dstreg_addrM,
    input  logic        write_regM,
    input  logic [4:0]  dstreg_addrW,
    input  logic        write_regW,
    input  logic        mdu_done,
    output logic [1:0]  fwd_aE,
    output logic [1:0]  fwd_bE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        mdu_start,
    output logic        mdu_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MDU_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       load_use;
    logic       start_req;

    forward_unit u_forward_unit (
        .rs1_addr_i (rs1_addrE),
        .rs2_addr_i (rs2_addrE),
        .dst_m_i    (dstreg_addrM),
        .wr_m_i     (write_regM),
        .dst_w_i    (dstreg_addrW),
        .wr_w_i     (write_regW),
        .fwd_a_o    (fwd_aE),
        .fwd_b_o    (fwd_bE)
    );

    always_comb begin
        load_use = (info_loadE != 3'd0) && write_regE && (dstreg_addrE != 5'd0) &&
                   ((uses_rs1D && (rs1_addrD == dstreg_addrE)) ||
                    (uses_rs2D && (rs2_addrD == dstreg_addrE)));
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        start_req = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_takenE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (mdu_reqD) begin
                    // Hold the MDU op in decode while the unit works on it.
                    start_req = 1'b1;
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    flushE    = 1'b1;
                    tmo_d     = 8'd0;
                    state_d   = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = RUN;
                end else begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    if (tmo_q == TIMEOUT_LAST) begin
                        // Watchdog abort: discard the stalled MDU op from decode.
                        flushD  = 1'b1;
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Gated so the start pulse cannot escape while reset is held.
    assign mdu_start = start_req & rst_n;
    assign mdu_error = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flushD || flushE) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MDU_TIMEOUT = 8).
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE;
    logic        uses_rs1D, uses_rs2D, mdu_reqD;
    logic [4:0]  dstreg_addrE, dstreg_addrM, dstreg_addrW;
    logic        write_regE, write_regM, write_regW;
    logic [2:0]  info_loadE;
    logic        branch_takenE, mdu_done;
    logic [1:0]  fwd_aE, fwd_bE;
    logic        stallF, stallD, flushD, flushE, mdu_start, mdu_error;
    logic [31:0] stall_cycles, flush_count;
    logic [4:0]  ctl;

    int n_tests = 0;
    int n_fail  = 0;

    // {stallF, stallD, flushD, flushE, mdu_start}
    assign ctl = {stallF, stallD, flushD, flushE, mdu_start};

    always #5 clk = ~clk;

    hazard_controller #(.MDU_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_addrD     (rs1_addrD),
        .rs2_addrD     (rs2_addrD),
        .uses_rs1D     (uses_rs1D),
        .uses_rs2D     (uses_rs2D),
        .mdu_reqD      (mdu_reqD),
        .rs1_addrE     (rs1_addrE),
        .rs2_addrE     (rs2_addrE),
        .dstreg_addrE  (dstreg_addrE),
        .write_regE    (write_regE),
        .info_loadE    (info_loadE),
        .branch_takenE (branch_takenE),
        .dstreg_addrM  (dstreg_addrM),
        .write_regM    (write_regM),
        .dstreg_addrW  (dstreg_addrW),
        .write_regW    (write_regW),
        .mdu_done      (mdu_done),
        .fwd_aE        (fwd_aE),
        .fwd_bE        (fwd_bE),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushD        (flushD),
        .flushE        (flushE),
        .mdu_start     (mdu_start),
        .mdu_error     (mdu_error),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic idle();
        rs1_addrD = 5'd0; rs2_addrD = 5'd0; uses_rs1D = 1'b0; uses_rs2D = 1'b0;
        mdu_reqD = 1'b0; rs1_addrE = 5'd0; rs2_addrE = 5'd0; dstreg_addrE = 5'd0;
        write_regE = 1'b0; info_loadE = 3'd0; branch_takenE = 1'b0;
        dstreg_addrM = 5'd0; write_regM = 1'b0; dstreg_addrW = 5'd0; write_regW = 1'b0;
        mdu_done = 1'b0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        to_negedge();
        rst_n = 1'b0;
        to_negedge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ctl, mdu_error} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=000000", {ctl, mdu_error});
        end
        n_tests++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        // Outputs follow RUN equations while reset is held.
        info_loadE = 3'b001; write_regE = 1'b1; dstreg_addrE = 5'd9;
        rs1_addrD = 5'd9; uses_rs1D = 1'b1; mdu_reqD = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11010) begin
            n_fail++; $display("FAIL reset_loaduse got=%b exp=11010", ctl);
        end
        idle();
        mdu_reqD = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11010) begin
            n_fail++; $display("FAIL reset_mdu_start got=%b exp=11010", ctl);
        end
        idle();
        to_negedge();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_forward();
        logic [4:0] ra [6];
        logic [4:0] rb [6];
        logic [4:0] dm [6];
        logic       wm [6];
        logic [4:0] dw [6];
        logic       ww [6];
        logic [3:0] exp [6];
        // rs1, rs2, dstM, wrM, dstW, wrW -> {fwd_a, fwd_b}
        ra = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd4, 5'd6};
        rb = '{5'd1, 5'd1, 5'd0, 5'd4, 5'd4, 5'd7};
        dm = '{5'd5, 5'd0, 5'd0, 5'd3, 5'd4, 5'd6};
        wm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dw = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd4, 5'd7};
        ww = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp = '{4'b1000, 4'b0100, 4'b0000, 4'b0100, 4'b1010, 4'b1001};
        for (int i = 0; i < 6; i++) begin
            idle();
            rs1_addrE = ra[i]; rs2_addrE = rb[i];
            dstreg_addrM = dm[i]; write_regM = wm[i];
            dstreg_addrW = dw[i]; write_regW = ww[i];
            #1;
            n_tests++;
            if ({fwd_aE, fwd_bE} !== exp[i]) begin
                n_fail++;
                $display("FAIL forward_%0d got=%b exp=%b", i, {fwd_aE, fwd_bE}, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        to_negedge();
        idle();
        info_loadE = 3'b010; dstreg_addrE = 5'd7; write_regE = 1'b1;
        rs2_addrD = 5'd7; uses_rs2D = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11010) begin
            n_fail++; $display("FAIL loaduse_rs2 got=%b exp=11010", ctl);
        end
        to_negedge();
        info_loadE = 3'd0;
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL loaduse_cleared got=%b exp=00000", ctl);
        end
        info_loadE = 3'b010; uses_rs2D = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL loaduse_unused got=%b exp=00000", ctl);
        end
        rs1_addrD = 5'd7; uses_rs1D = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11010) begin
            n_fail++; $display("FAIL loaduse_rs1 got=%b exp=11010", ctl);
        end
        dstreg_addrE = 5'd0; rs1_addrD = 5'd0;
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL loaduse_x0 got=%b exp=00000", ctl);
        end
        idle();
    endtask

    task automatic test_branch();
        to_negedge();
        idle();
        info_loadE = 3'b010; dstreg_addrE = 5'd7; write_regE = 1'b1;
        rs2_addrD = 5'd7; uses_rs2D = 1'b1; branch_takenE = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b00110) begin
            n_fail++; $display("FAIL branch_over_loaduse got=%b exp=00110", ctl);
        end
        info_loadE = 3'd0; mdu_reqD = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b00110) begin
            n_fail++; $display("FAIL branch_over_mdu got=%b exp=00110", ctl);
        end
        // Branch must not have launched the MDU: next cycle is still RUN.
        to_negedge();
        idle();
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL branch_no_wait got=%b exp=00000", ctl);
        end
    endtask

    task automatic test_mdu_done();
        pulse_reset();
        idle();
        mdu_reqD = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11011) begin
            n_fail++; $display("FAIL mdu_start got=%b exp=11011", ctl);
        end
        for (int i = 1; i <= 4; i++) begin
            to_negedge();
            #1;
            n_tests++;
            if (ctl !== 5'b11010) begin
                n_fail++; $display("FAIL mdu_wait_%0d got=%b exp=11010", i, ctl);
            end
        end
        to_negedge();
        mdu_done = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL mdu_done_drop got=%b exp=00000", ctl);
        end
        to_negedge();
        idle();
        #1;
        n_tests++;
        if ({ctl, mdu_error} !== 6'b0) begin
            n_fail++; $display("FAIL mdu_back_run got=%b exp=000000", {ctl, mdu_error});
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if ({stall_cycles, flush_count} !== {32'd5, 32'd5}) begin
            n_fail++; $display("FAIL perf_mdu got=%0d/%0d exp=5/5", stall_cycles, flush_count);
        end
`else
        n_tests++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            n_fail++; $display("FAIL perf_off got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
`endif
        // A stray done while in RUN does nothing.
        to_negedge();
        mdu_done = 1'b1;
        #1;
        to_negedge();
        mdu_done = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL done_in_run got=%b exp=00000", ctl);
        end
    endtask

    task automatic test_timeout();
        to_negedge();
        idle();
        mdu_reqD = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 5'b11011) begin
            n_fail++; $display("FAIL tmo_start got=%b exp=11011", ctl);
        end
        for (int i = 1; i <= 8; i++) begin
            to_negedge();
            mdu_reqD = 1'b0;
            #1;
            n_tests++;
            if (ctl !== ((i == 8) ? 5'b11110 : 5'b11010)) begin
                n_fail++; $display("FAIL tmo_wait_%0d got=%b", i, ctl);
            end
        end
        to_negedge();
        #1;
        n_tests++;
        if ({ctl, mdu_error} !== 6'b000001) begin
            n_fail++; $display("FAIL tmo_error got=%b exp=000001", {ctl, mdu_error});
        end
        repeat (3) to_negedge();
        #1;
        n_tests++;
        if (mdu_error !== 1'b1) begin
            n_fail++; $display("FAIL tmo_sticky got=%b exp=1", mdu_error);
        end
    endtask

    task automatic test_reset_mid_wait();
        to_negedge();
        idle();
        mdu_reqD = 1'b1;
        repeat (3) to_negedge();
        mdu_reqD = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 5'b11010) begin
            n_fail++; $display("FAIL rst_pre_wait got=%b exp=11010", ctl);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ctl, mdu_error} !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid_wait got=%b exp=000000", {ctl, mdu_error});
        end
        n_tests++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            n_fail++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        to_negedge();
        rst_n = 1'b1;
        to_negedge();
        #1;
        n_tests++;
        if ({ctl, mdu_error} !== 6'b0) begin
            n_fail++; $display("FAIL rst_run got=%b exp=000000", {ctl, mdu_error});
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mdu_done();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
